mem_readback_ctrl: RTL and testbench

- Readback counterpart of the program loader: on request, reads a block of words out of instruction or data memory and emits them as a valid/ready stream for the host dump path.
- Sits between the memory read ports and the host link; drives `busy` so the top level holds the CPU, like the programming flag.
- Strictly sequential: one memory read per emitted word; back-pressure is honoured via `dout_rdy`.

---
 rtl/mem_readback_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_readback_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback_ctrl.sv
// Block readback controller: streams a run of words from instruction or data
// memory out as a valid/ready stream, holding busy while the block is in progress.
module mem_readback_ctrl #(
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic [31:0]      ins_rd_addr,
  output logic             ins_rd_en,
  input  logic [31:0]      ins_rd_data,
  output logic [31:0]      data_rd_addr,
  output logic             data_rd_en,
  input  logic [31:0]      data_rd_data,
  output logic [31:0]      dout,
  output logic [31:0]      dout_addr,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [1:0]       LAT_INIT = 2'(RD_LAT - 1);
  localparam logic [31:0]      STEP     = 32'(ADDR_STEP);
  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       lat_q, lat_d;
  logic [31:0]      dout_q, dout_d;
  logic [31:0]      dout_addr_q, dout_addr_d;

  // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      lat_q       <= '0;
      dout_q      <= '0;
      dout_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      dout_q      <= dout_d;
      dout_addr_q <= dout_addr_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    lat_d        = lat_q;
    dout_d       = dout_q;
    dout_addr_d  = dout_addr_q;
    ins_rd_en    = 1'b0;
    ins_rd_addr  = '0;
    data_rd_en   = 1'b0;
    data_rd_addr = '0;
    dout_vld     = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d       = sel;
          cur_addr_d  = base_addr;
          remaining_d = word_cnt;
          state_d     = (word_cnt == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (sel_q) begin
          data_rd_en   = 1'b1;
          data_rd_addr = cur_addr_q;
        end else begin
          ins_rd_en   = 1'b1;
          ins_rd_addr = cur_addr_q;
        end
        lat_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q != 2'd0) begin
          lat_d = lat_q - 2'd1;
        end else begin
          dout_d      = sel_q ? data_rd_data : ins_rd_data;
          dout_addr_d = cur_addr_q;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        dout_vld = 1'b1;
        if (dout_rdy) begin
          remaining_d = remaining_q - ONE;
          cur_addr_d  = cur_addr_q + STEP;
          state_d     = (remaining_q == ONE) ? S_FIN : S_READ;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dout      = dout_q;
  assign dout_addr = dout_addr_q;

endmodule

// File: tb/tb_mem_readback_ctrl.sv
// Bench for mem_readback_ctrl: latency-accurate memory models and a queue of
// expected (address, data) words that is popped on every stream transfer.
module tb_mem_readback_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks   = 0;
  int          failures = 0;

  // RD_LAT = 1 instance
  logic        start, sel, dout_rdy;
  logic [31:0] base_addr;
  logic [15:0] word_cnt;
  logic [31:0] ins_rd_addr, ins_rd_data, data_rd_addr, data_rd_data;
  logic        ins_rd_en, data_rd_en;
  logic [31:0] dout, dout_addr;
  logic        dout_vld, busy, done;

  // RD_LAT = 2 instance
  logic        start2, sel2, dout_rdy2;
  logic [31:0] base_addr2;
  logic [15:0] word_cnt2;
  logic [31:0] ins_rd_addr2, ins_rd_data2, data_rd_addr2, data_rd_data2;
  logic        ins_rd_en2, data_rd_en2;
  logic [31:0] dout2, dout_addr2;
  logic        dout_vld2, busy2, done2;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  logic [31:0] ins_log[$];
  logic [31:0] data_log[$];
  logic [31:0] ins_pipe, data_pipe, ins2_s0, ins2_s1, data2_s0, data2_s1;

  always #5 clk = ~clk;

  mem_readback_ctrl #(.CNT_W(16), .ADDR_STEP(4), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .base_addr(base_addr), .word_cnt(word_cnt),
    .ins_rd_addr(ins_rd_addr), .ins_rd_en(ins_rd_en), .ins_rd_data(ins_rd_data),
    .data_rd_addr(data_rd_addr), .data_rd_en(data_rd_en), .data_rd_data(data_rd_data),
    .dout(dout), .dout_addr(dout_addr), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .busy(busy), .done(done)
  );

  mem_readback_ctrl #(.CNT_W(16), .ADDR_STEP(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sel(sel2),
    .base_addr(base_addr2), .word_cnt(word_cnt2),
    .ins_rd_addr(ins_rd_addr2), .ins_rd_en(ins_rd_en2), .ins_rd_data(ins_rd_data2),
    .data_rd_addr(data_rd_addr2), .data_rd_en(data_rd_en2), .data_rd_data(data_rd_data2),
    .dout(dout2), .dout_addr(dout_addr2), .dout_vld(dout_vld2), .dout_rdy(dout_rdy2),
    .busy(busy2), .done(done2)
  );

  function automatic logic [31:0] ins_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] data_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'h1000 + ((a - 32'h100) >> 2);
    return a ^ 32'h3C3C_0000;
  endfunction

  // Memory models: data only valid exactly RD_LAT cycles after the strobe.
  always @(posedge clk) begin
    if (ins_rd_en)  ins_log.push_back(ins_rd_addr);
    if (data_rd_en) data_log.push_back(data_rd_addr);
    ins_pipe  <= ins_rd_en  ? ins_word(ins_rd_addr)   : 32'hBAD0_0001;
    data_pipe <= data_rd_en ? data_word(data_rd_addr) : 32'hBAD0_0002;
    ins2_s0   <= ins_rd_en2  ? ins_word(ins_rd_addr2)   : 32'hBAD0_0003;
    data2_s0  <= data_rd_en2 ? data_word(data_rd_addr2) : 32'hBAD0_0004;
    ins2_s1   <= ins2_s0;
    data2_s1  <= data2_s0;
  end

  assign ins_rd_data   = ins_pipe;
  assign data_rd_data  = data_pipe;
  assign ins_rd_data2  = ins2_s1;
  assign data_rd_data2 = data2_s1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic s, input logic [31:0] base, input logic [15:0] cnt);
    exp_t e;
    for (int i = 0; i < int'(cnt); i++) begin
      e.addr = base + 32'(4 * i);
      e.data = s ? data_word(e.addr) : ins_word(e.addr);
      exp_q.push_back(e);
    end
    sel = s; base_addr = base; word_cnt = cnt; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected transfer addr=%h data=%h", name, dout_addr, dout);
    end else begin
      e = exp_q.pop_front();
      if (dout !== e.data || dout_addr !== e.addr) begin
        failures++;
        $display("FAIL %s: got addr=%h data=%h expected addr=%h data=%h",
                 name, dout_addr, dout, e.addr, e.data);
      end
    end
  endtask

  // Runs until done; optionally stalls word hold_word for hold_cycles while checking stability.
  task automatic drain(input string name, input int budget, input int hold_word,
                       input int hold_cycles, output int transfers, output int vld_cycles,
                       output int done_at);
    int   held = 0;
    logic snap_ok = 1'b0;
    logic [31:0] snap_d, snap_a;
    transfers = 0; vld_cycles = 0; done_at = -1;
    for (int k = 0; k < budget; k++) begin
      if (k > 0) tick();
      dout_rdy = 1'b1;
      if (dout_vld) begin
        vld_cycles++;
        if (transfers == hold_word) begin
          if (!snap_ok) begin
            snap_d = dout; snap_a = dout_addr; snap_ok = 1'b1;
          end else begin
            checks++;
            if (dout !== snap_d || dout_addr !== snap_a) begin
              failures++;
              $display("FAIL %s_stable: got addr=%h data=%h expected addr=%h data=%h",
                       name, dout_addr, dout, snap_a, snap_d);
            end
          end
          if (held < hold_cycles) begin
            dout_rdy = 1'b0;
            held++;
          end
        end
        if (dout_rdy) begin
          pop_compare(name);
          transfers++;
        end
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
    checks++;
    if (done_at < 0) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    dout_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({ins_rd_en, data_rd_en, ins_rd_addr, data_rd_addr, dout, dout_addr,
         dout_vld, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b%b ia=%h da=%h dout=%h daddr=%h vld=%b busy=%b done=%b expected all zero",
               ins_rd_en, data_rd_en, ins_rd_addr, data_rd_addr, dout, dout_addr,
               dout_vld, busy, done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_ins();
    ins_log.delete(); data_log.delete();
    dout_rdy = 1'b1;
    start_block(1'b0, 32'h40, 16'd1);
    checks++;
    if ({ins_rd_en, ins_rd_addr, data_rd_en, busy} !== {1'b1, 32'h40, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_read: got en=%b addr=%h den=%b busy=%b expected en=1 addr=00000040 den=0 busy=1",
               ins_rd_en, ins_rd_addr, data_rd_en, busy);
    end
    tick();
    checks++;
    if ({ins_rd_en, dout_vld} !== 2'b00) begin
      failures++;
      $display("FAIL single_wait: got en=%b vld=%b expected 0 0", ins_rd_en, dout_vld);
    end
    tick();
    checks++;
    if (dout_vld !== 1'b1) begin
      failures++;
      $display("FAIL single_vld: got vld=%b expected 1", dout_vld);
    end
    if (dout_vld) pop_compare("single_data");
    tick();
    checks++;
    if ({dout_vld, done, busy} !== 3'b011) begin
      failures++;
      $display("FAIL single_done: got vld=%b done=%b busy=%b expected 0 1 1", dout_vld, done, busy);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle: got done=%b busy=%b expected 0 0", done, busy);
    end
    checks++;
    if (ins_log.size() != 1 || data_log.size() != 0) begin
      failures++;
      $display("FAIL single_reads: got ins=%0d data=%0d expected ins=1 data=0",
               ins_log.size(), data_log.size());
    end
  endtask

  task automatic test_data_backpressure();
    int tr, vc, da;
    data_log.delete();
    start_block(1'b1, 32'h100, 16'd4);
    drain("bp", 200, 2, 5, tr, vc, da);
    checks++;
    if (tr != 4 || exp_q.size() != 0 || data_log.size() != 4) begin
      failures++;
      $display("FAIL bp_count: got transfers=%0d left=%0d reads=%0d expected 4 0 4",
               tr, exp_q.size(), data_log.size());
    end
    tick();
  endtask

  task automatic test_zero_count();
    int tr, vc, da;
    ins_log.delete(); data_log.delete();
    start_block(1'b0, 32'h80, 16'd0);
    drain("zero", 10, -1, 0, tr, vc, da);
    checks++;
    if (da < 0 || da > 1 || vc != 0 || ins_log.size() != 0 || data_log.size() != 0) begin
      failures++;
      $display("FAIL zero_cnt: got done_at=%0d vld_cycles=%0d reads=%0d/%0d expected done_at<=1 0 0/0",
               da, vc, ins_log.size(), data_log.size());
    end
    tick();
  endtask

  task automatic test_wrap();
    int tr, vc, da;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    ins_log.delete();
    start_block(1'b0, 32'hFFFF_FFF8, 16'd3);
    drain("wrap", 100, -1, 0, tr, vc, da);
    checks++;
    if (ins_log.size() != 3) begin
      failures++;
      $display("FAIL wrap_reads: got %0d reads expected 3", ins_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ins_log[i] !== want[i]) begin
          failures++;
          $display("FAIL wrap_addr%0d: got %h expected %h", i, ins_log[i], want[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_start_busy_reset();
    int tr, vc, da;
    int n;
    ins_log.delete(); data_log.delete();
    dout_rdy = 1'b0;
    start_block(1'b1, 32'h200, 16'd2);
    n = 0;
    while (!dout_vld && n < 20) begin
      tick(); n++;
    end
    sel = 1'b0; base_addr = 32'h300; word_cnt = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    drain("busy_start", 100, -1, 0, tr, vc, da);
    checks++;
    if (tr != 2 || ins_log.size() != 0 || data_log.size() != 2) begin
      failures++;
      $display("FAIL busy_start_ignored: got transfers=%0d ins=%0d data=%0d expected 2 0 2",
               tr, ins_log.size(), data_log.size());
    end
    tick();
    start_block(1'b1, 32'h400, 16'd3);
    tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    checks++;
    if ({ins_rd_en, data_rd_en, ins_rd_addr, data_rd_addr, dout, dout_addr,
         dout_vld, busy, done} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got en=%b%b dout=%h daddr=%h vld=%b busy=%b done=%b expected all zero",
               ins_rd_en, data_rd_en, dout, dout_addr, dout_vld, busy, done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({done, busy, dout_vld} !== 3'b000) begin
        failures++;
        $display("FAIL midreset_idle%0d: got done=%b busy=%b vld=%b expected 0 0 0",
                 i, done, busy, dout_vld);
      end
    end
    start_block(1'b0, 32'h500, 16'd2);
    drain("after_reset", 100, -1, 0, tr, vc, da);
    checks++;
    if (tr != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset_count: got transfers=%0d left=%0d expected 2 0", tr, exp_q.size());
    end
    tick();
  endtask

  task automatic test_lat2();
    exp_t e;
    int   rd_k = -100;
    int   rises = 0;
    int   xfers = 0;
    logic prev_vld = 1'b0;
    logic got_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.addr = 32'h100 + 32'(4 * i);
      e.data = data_word(e.addr);
      exp2_q.push_back(e);
    end
    sel2 = 1'b1; base_addr2 = 32'h100; word_cnt2 = 16'd2; dout_rdy2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      if (k > 0) tick();
      if (data_rd_en2) rd_k = k;
      if (dout_vld2 && !prev_vld) begin
        rises++;
        checks++;
        if (k - rd_k != 3) begin
          failures++;
          $display("FAIL lat2_rise: got %0d cycles after READ expected 3", k - rd_k);
        end
      end
      prev_vld = dout_vld2;
      if (dout_vld2 && dout_rdy2) begin
        xfers++;
        checks++;
        if (exp2_q.size() == 0) begin
          failures++;
          $display("FAIL lat2_data: unexpected transfer data=%h", dout2);
        end else begin
          e = exp2_q.pop_front();
          if (dout2 !== e.data || dout_addr2 !== e.addr) begin
            failures++;
            $display("FAIL lat2_data: got addr=%h data=%h expected addr=%h data=%h",
                     dout_addr2, dout2, e.addr, e.data);
          end
        end
      end
      if (done2) got_done = 1'b1;
    end
    checks++;
    if (!got_done || rises != 2 || xfers != 2) begin
      failures++;
      $display("FAIL lat2_block: got done=%b rises=%0d transfers=%0d expected 1 2 2",
               got_done, rises, xfers);
    end
  endtask

  initial begin
    start = 1'b0; sel = 1'b0; base_addr = '0; word_cnt = '0; dout_rdy = 1'b1;
    start2 = 1'b0; sel2 = 1'b0; base_addr2 = '0; word_cnt2 = '0; dout_rdy2 = 1'b1;
    test_reset();
    test_single_ins();
    test_data_backpressure();
    test_zero_count();
    test_wrap();
    test_start_busy_reset();
    test_lat2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
